// File: rtl/sixty_four_bit_shift_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sixty_four_bit_shift_register                                    |
// | Desc   : PC register with load / 1-bit shift left / shift right / hold.   |
// |          Optional macro SHIFT_ROTATE_EN turns both shifts into rotates.   |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
module sixty_four_bit_shift_register #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             shiftLeft,
  input  logic             shiftRight,
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] c_MODE_LOAD  = 2'b00;
  localparam logic [1:0] c_MODE_RIGHT = 2'b01;
  localparam logic [1:0] c_MODE_LEFT  = 2'b10;
  localparam logic [1:0] c_MODE_HOLD  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_d;
  logic [1:0]       w_mode;

  assign w_mode = {shiftLeft, shiftRight};

  always_comb begin
    w_d = r_q;
    case (w_mode)
      c_MODE_LOAD:  w_d = in;
`ifdef SHIFT_ROTATE_EN
      c_MODE_LEFT:  w_d = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      c_MODE_RIGHT: w_d = {r_q[0], r_q[WIDTH-1:1]};
`else
      // Fill bits come from the parallel input so the caller can steer them.
      c_MODE_LEFT:  w_d = {r_q[WIDTH-2:0], in[0]};
      c_MODE_RIGHT: w_d = {in[WIDTH-1], r_q[WIDTH-1:1]};
`endif
      c_MODE_HOLD:  w_d = r_q;
      default:      w_d = r_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_d;
    end
  end

  assign out = r_q;

endmodule
`default_nettype wire

// File: tb/tb_sixty_four_bit_shift_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_sixty_four_bit_shift_register                                 |
// | Desc   : Directed + random self-checking bench against an arithmetic      |
// |          reference model; honours SHIFT_ROTATE_EN like the design.        |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
module tb_sixty_four_bit_shift_register;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in = '0;
  logic        shiftLeft = 1'b0;
  logic        shiftRight = 1'b0;
  logic [63:0] out;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] model = '0;

  sixty_four_bit_shift_register #(.WIDTH(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .in         (in),
    .shiftLeft  (shiftLeft),
    .shiftRight (shiftRight),
    .out        (out)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_next(input logic [63:0] q, input logic r,
                                           input logic sl, input logic sr,
                                           input logic [63:0] d);
    logic [63:0] top_bit;
    top_bit = 64'h8000_0000_0000_0000;
    if (r) return 64'd0;
    if (!sl && !sr) return d;
    if (sl && sr) return q;
`ifdef SHIFT_ROTATE_EN
    if (sl) return (q * 2) + (q / top_bit);
    return (q / 2) + ((q % 2) * top_bit);
`else
    if (sl) return (q * 2) + (d % 2);
    return (q / 2) + ((d / top_bit) * top_bit);
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] expected);
    vectors++;
    assert (out === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, out, expected);
    end
  endtask

  task automatic step(input logic r, input logic sl, input logic sr,
                      input logic [63:0] d, input string tag);
    @(negedge clock);
    reset = r; shiftLeft = sl; shiftRight = sr; in = d;
    @(posedge clock);
    #1;
    model = ref_next(model, r, sl, sr, d);
    check(tag, model);
  endtask

  initial begin
    // Reset behaviour
    step(1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001, "reset_first");
    check("reset_is_zero", 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001, "reset_hold");

    // PC loop with external +4 adder
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, model + 64'd4, "pc_loop");
    check("pc_loop_12", 64'd12);
    step(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, "pc_preload");
    step(1'b0, 1'b0, 1'b0, model + 64'd4, "pc_wrap");
    check("pc_wrap_zero", 64'd0);

    // Shift left
    step(1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0001, "sl_load");
    step(1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_0001, "sl_fill1");
    check("sl_fill1_val", 64'h3);
    step(1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, "sl_load2");
    step(1'b0, 1'b1, 1'b0, 64'h0, "sl_fill0");
`ifdef SHIFT_ROTATE_EN
    check("sl_rot_val", 64'h1);
`else
    check("sl_fill0_val", 64'h0);
`endif

    // Shift right
    step(1'b0, 1'b0, 1'b0, 64'h1, "sr_load");
    step(1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, "sr_fill1");
    check("sr_fill1_val", 64'h8000_0000_0000_0000);
    step(1'b0, 1'b0, 1'b1, 64'h0, "sr_fill0");

    // Hold with toggling input
    step(1'b0, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, "hold_load");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0, "hold");
    end
    check("hold_val", 64'h1234_5678_9ABC_DEF0);

    // Mid-cycle input glitches must not reach the output
    in = 64'hA5A5_A5A5_A5A5_A5A5; shiftLeft = 1'b0; shiftRight = 1'b0;
    #2;
    in = 64'h5A5A_5A5A_5A5A_5A5A; shiftRight = 1'b1;
    #1;
    check("no_comb_path", 64'h1234_5678_9ABC_DEF0);

    // Reset in the middle of a left-shift run
    step(1'b0, 1'b0, 1'b0, 64'h0F0F_0000_0000_00F0, "rs_load");
    step(1'b0, 1'b1, 1'b0, 64'h1, "rs_shift");
    step(1'b1, 1'b1, 1'b0, 64'h1, "rs_reset");
    check("rs_reset_zero", 64'h0);
    step(1'b0, 1'b1, 1'b0, 64'h1, "rs_resume1");
    step(1'b0, 1'b1, 1'b0, 64'h0, "rs_resume2");

    // Random mix of modes, data and occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [63:0] d;
      logic        r;
      d = {$urandom, $urandom};
      r = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) d = model + 64'd4;
      step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sixty_four_bit_shift_register.md
# sixty_four_bit_shift_register

Clocked 64-bit storage register with parallel load, one-bit left/right shift and hold, selected per cycle by two control strobes. It serves as the program-counter register in the CPU datapath: `out` feeds the 64-bit adder (`out + 4`, carry-in 0), and the adder's `sum` returns on `in`. All state changes occur on the rising edge of `clock`; `out` is driven directly from the register.

## Interface
- `WIDTH`, default 64, register and data-path width in bits; only 64 is required to be supported.
- `clock`  input  1  rising-edge clock; the block's only clock.
- `reset`  input  1  synchronous, active-high reset; clears the register on the next rising edge.
- `in`  input  WIDTH  parallel-load data; also supplies the serial fill bit for shifts.
- `shiftLeft`  input  1  shift-left request.
- `shiftRight`  input  1  shift-right request.
- `out`  output  WIDTH  current register contents.

## Operation
- Mode is decoded from {shiftLeft, shiftRight}:
  - 00: parallel load, next = in.
  - 10: shift left, next = {q[62:0], in[0]}.
  - 01: shift right, next = {in[63], q[63:1]}.
  - 11: hold, next = q (conflicting request, no change).
- `reset` has priority over every mode: next = 64'h0 regardless of `shiftLeft`, `shiftRight` and `in`.
- Shifts are logical, by exactly one position per cycle; the bit shifted out is discarded; no carry or status outputs.
- `in` is sampled only at the rising edge; glitches between edges have no effect.
- No internal combinational path from `in` or the strobes to `out`; the feedback loop through the external adder is therefore legal with no combinational cycle.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on `out` after edge N (valid for the cycle following N).
- Reset value: `out` = 0 after the first rising edge with `reset`=1. Before that edge `out` is undefined (X in simulation).
- Reset mid-operation: a `reset` pulse of one cycle clears the register at that edge; the mode applied on the following edge operates on 0.
- Reset deasserted: the first edge with `reset`=0 performs the selected mode on the cleared value.
- Mode may change every cycle; no handshake, no busy state.
- Wrap-around: in load mode with external `out + 4`, 64'hFFFF_FFFF_FFFF_FFFC loads to 0 (adder carry-out ignored by this block).

## Configuration
- `SHIFT_ROTATE_EN` defined: shift modes rotate. 10 gives next = {q[62:0], q[63]}, and 01 gives next = {q[0], q[63:1]}. `in` is ignored in shift modes.
- `SHIFT_ROTATE_EN` undefined (default): shift fill bits come from `in[0]` (left) and `in[63]` (right), as specified in Operation.
- Load, hold, reset and timing behaviour are identical in both builds.

## Test plan
- Reset: `reset`=1 for one edge with in=64'hDEAD_BEEF_0000_0001 and mode 00 -> `out`=0; hold `reset`=1 for 3 edges -> `out` stays 0.
- Load and PC loop: release reset, mode 00, adder feedback `in`=`out`+4 -> `out` = 4, 8, 12 on successive edges; preload 64'hFFFF_FFFF_FFFF_FFFC -> next `out`=0.
- Shift left: load 64'h8000_0000_0000_0001, mode 10 with in[0]=1 -> 64'h0000_0000_0000_0003; with the `SHIFT_ROTATE_EN` build and the same load -> 64'h0000_0000_0000_0003. Then load 64'h8000_0000_0000_0000, shift with in[0]=0 -> default build 0; rotate build 64'h1.
- Shift right: load 64'h1, mode 01 with in[63]=1 -> 64'h8000_0000_0000_0000 (default build); rotate build from 64'h1 -> 64'h8000_0000_0000_0000 independent of `in`.
- Hold and conflict: load 64'h1234_5678_9ABC_DEF0, mode 11 for 4 edges with `in` toggling -> `out` unchanged.
- Reset mid-shift: mode 10 running, `reset`=1 on one edge with mode 10 still applied -> `out`=0 at that edge, then shifting resumes from 0 (fill from in[0]).
